wash_cycle_sequencer: RTL and testbench

//   Master controller for one washing-machine run. Drives the phase timer and reacts to its done flag.

---
 rtl/wash_cycle_sequencer.sv | 139 +++++++++++++
 tb/tb_wash_cycle_sequencer.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wash_cycle_sequencer.sv
// Master controller for one washing-machine run: coin, door check, then timed FILL/WASH/RINSE/SPIN.
// Latency: one state step per clock; tmr_enable reacts to timer_pause combinationally in SPIN.
// Backpressure: none; the timer's done flag alone advances timed phases, pause stalls only SPIN.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-low reset
//   coin_in             starts a run (looked at only in IDLE), double_wash latched alongside it
//   door_closed         gates CHECK_DOOR -> FILL
//   timer_pause         holds the timer during SPIN only
//   tmr_done            expiry flag from the phase timer
//   tmr_clear/enable    timer control: clear on the first cycle of a phase, count afterwards
//   tmr_clk_freq        constant ticks per second for the timer
//   tmr_period          current phase length in seconds (0 outside timed phases)
//   phase               0 IDLE, 1 CHECK_DOOR, 2 FILL, 3 WASH, 4 RINSE, 5 SPIN
//   wash_done           one-cycle pulse on the first IDLE cycle after SPIN
module wash_cycle_sequencer #(
  parameter logic [15:0] CLK_FREQ   = 16'd5,
  parameter logic [15:0] FILL_TIME  = 16'd2,
  parameter logic [15:0] WASH_TIME  = 16'd5,
  parameter logic [15:0] RINSE_TIME = 16'd2,
  parameter logic [15:0] SPIN_TIME  = 16'd1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        coin_in,
  input  logic        double_wash,
  input  logic        door_closed,
  input  logic        timer_pause,
  input  logic        tmr_done,
  output logic        tmr_clear,
  output logic        tmr_enable,
  output logic [15:0] tmr_clk_freq,
  output logic [15:0] tmr_period,
  output logic [2:0]  phase,
  output logic        wash_done
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_CHECK_DOOR = 3'd1,
    S_FILL       = 3'd2,
    S_WASH       = 3'd3,
    S_RINSE      = 3'd4,
    S_SPIN       = 3'd5
  } state_t;

  state_t state, state_nxt;

  // first_q marks the opening (clear) cycle of a timed phase.
  // second_q remembers a pending second WASH/RINSE pass.
  // done_q marks the IDLE cycle that directly follows SPIN.
  logic first_q, first_nxt;
  logic second_q, second_nxt;
  logic done_q, done_nxt;
  logic timed;
  logic expired;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      first_q  <= 1'b0;
      second_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      first_q  <= first_nxt;
      second_q <= second_nxt;
      done_q   <= done_nxt;
    end
  end

  // tmr_enable is already low on the clear cycle and while paused, so a done
  // flag seen then (stale count from the previous phase, or a held count)
  // cannot end the phase.
  assign expired = tmr_enable && tmr_done;

  // Next-state logic
  always_comb begin
    state_nxt  = state;
    second_nxt = second_q;
    done_nxt   = 1'b0;
    case (state)
      S_IDLE: begin
        if (coin_in) begin
          state_nxt  = S_CHECK_DOOR;
          second_nxt = double_wash;
        end
      end
      S_CHECK_DOOR: begin
        if (door_closed) state_nxt = S_FILL;
      end
      S_FILL: begin
        if (expired) state_nxt = S_WASH;
      end
      S_WASH: begin
        if (expired) state_nxt = S_RINSE;
      end
      S_RINSE: begin
        if (expired) begin
          if (second_q) begin
            state_nxt  = S_WASH;
            second_nxt = 1'b0;
          end else begin
            state_nxt  = S_SPIN;
          end
        end
      end
      S_SPIN: begin
        if (expired) begin
          state_nxt = S_IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    // Any entry into a timed phase, including RINSE -> WASH, starts with a clear.
    first_nxt = (state_nxt != state) &&
                (state_nxt inside {S_FILL, S_WASH, S_RINSE, S_SPIN});
  end

  // Output logic
  always_comb begin
    timed        = state inside {S_FILL, S_WASH, S_RINSE, S_SPIN};
    tmr_clk_freq = CLK_FREQ;
    phase        = state;
    tmr_clear    = timed && first_q;
    tmr_enable   = timed && !first_q && !((state == S_SPIN) && timer_pause);
    wash_done    = (state == S_IDLE) && done_q;
    case (state)
      S_FILL:  tmr_period = FILL_TIME;
      S_WASH:  tmr_period = WASH_TIME;
      S_RINSE: tmr_period = RINSE_TIME;
      S_SPIN:  tmr_period = SPIN_TIME;
      default: tmr_period = 16'd0;
    endcase
  end

endmodule

// File: tb/tb_wash_cycle_sequencer.sv
module tb_wash_cycle_sequencer;
  localparam int F       = 5;
  localparam int T_FILL  = 2;
  localparam int T_WASH  = 5;
  localparam int T_RINSE = 2;
  localparam int T_SPIN  = 1;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        coin_in = 1'b0;
  logic        double_wash = 1'b0;
  logic        door_closed = 1'b0;
  logic        timer_pause = 1'b0;
  logic        tmr_done;
  logic        tmr_clear, tmr_enable, wash_done;
  logic [15:0] tmr_clk_freq, tmr_period;
  logic [2:0]  phase;
  logic        force_done = 1'b0;
  int          cnt = 0;

  int n_cmp = 0;
  int n_bad = 0;

  wash_cycle_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .coin_in      (coin_in),
    .double_wash  (double_wash),
    .door_closed  (door_closed),
    .timer_pause  (timer_pause),
    .tmr_done     (tmr_done),
    .tmr_clear    (tmr_clear),
    .tmr_enable   (tmr_enable),
    .tmr_clk_freq (tmr_clk_freq),
    .tmr_period   (tmr_period),
    .phase        (phase),
    .wash_done    (wash_done)
  );

  always #5 clk = ~clk;

  // Phase timer model driven by the DUT.
  always @(posedge clk) begin
    if (tmr_clear) cnt <= 0;
    else if (tmr_enable) cnt <= cnt + 1;
  end
  assign tmr_done = force_done | (cnt >= int'(tmr_clk_freq) * int'(tmr_period));

  typedef struct packed {
    logic [2:0]  ph;
    logic        clr;
    logic        en;
    logic [15:0] per;
    logic        done;
  } obs_t;

  typedef struct packed {
    logic coin;
    logic dw;
    logic door;
    logic pause;
    logic fdone;
  } drv_t;

  obs_t exp_q[$];
  drv_t drv_q[$];

  function automatic obs_t mk(int ph, bit clr, bit en, int per, bit done);
    obs_t o;
    o.ph = 3'(ph); o.clr = clr; o.en = en; o.per = 16'(per); o.done = done;
    return o;
  endfunction

  function automatic drv_t mkd(bit coin, bit dw, bit door, bit pause, bit fdone);
    drv_t d;
    d.coin = coin; d.dw = dw; d.door = door; d.pause = pause; d.fdone = fdone;
    return d;
  endfunction

  function automatic string fmt(obs_t o);
    return $sformatf("ph=%0d clr=%0b en=%0b per=%0d done=%0b", o.ph, o.clr, o.en, o.per, o.done);
  endfunction

  function automatic bit rb();
    return 1'($urandom);
  endfunction

  task automatic clear_q();
    exp_q.delete();
    drv_q.delete();
  endtask

  task automatic push(obs_t e, drv_t d);
    exp_q.push_back(e);
    drv_q.push_back(d);
  endtask

  task automatic push_idle(int n);
    for (int i = 0; i < n; i++) push(mk(0, 0, 0, 0, 0), mkd(0, rb(), rb(), rb(), 0));
  endtask

  // A timed phase lasts one clear cycle, F*secs counting cycles and one done
  // cycle; in SPIN every paused cycle after the clear adds one more.
  task automatic add_phase(int ph, int secs, int p_off, int p_len, bit drive_pause,
                           bit coin_at3, bit fdone_at0);
    int  n;
    bit  in_p, paused;
    n = F * secs + 2 + ((ph == 5) ? p_len : 0);
    for (int k = 0; k < n; k++) begin
      in_p   = (p_len > 0) && (k >= p_off) && (k < p_off + p_len);
      paused = (ph == 5) && in_p;
      push(mk(ph, k == 0, (k != 0) && !paused, secs, 0),
           mkd(coin_at3 && (k == 3), rb(), rb(), drive_pause && in_p, fdone_at0 && (k == 0)));
    end
  endtask

  task automatic build_run(bit dw, int door_delay, int spin_off, int spin_len,
                           int wash_off, int wash_len, bit wash_coin, bit stale, bit merge);
    drv_t last;
    if (merge) begin
      last = drv_q.pop_back();
      last.coin = 1'b1;
      last.dw   = dw;
      drv_q.push_back(last);
    end else begin
      push(mk(0, 0, 0, 0, 0), mkd(1, dw, 0, rb(), 0));
    end
    for (int j = 0; j <= door_delay; j++)
      push(mk(1, 0, 0, 0, 0), mkd(0, rb(), j == door_delay, rb(), 0));
    add_phase(2, T_FILL, 0, 0, 0, 0, 0);
    add_phase(3, T_WASH, wash_off, wash_len, 1, wash_coin, stale);
    add_phase(4, T_RINSE, 0, 0, 0, 0, 0);
    if (dw) begin
      add_phase(3, T_WASH, 0, 0, 0, 0, 0);
      add_phase(4, T_RINSE, 0, 0, 0, 0, 0);
    end
    add_phase(5, T_SPIN, spin_off, spin_len, 1, 0, 0);
    push(mk(0, 0, 0, 0, 1), mkd(0, rb(), rb(), rb(), 0));
  endtask

  task automatic step(input drv_t d, output obs_t o);
    @(posedge clk);
    #1;
    coin_in     = d.coin;
    double_wash = d.dw;
    door_closed = d.door;
    timer_pause = d.pause;
    force_done  = d.fdone;
    @(negedge clk);
    o = '{phase, tmr_clear, tmr_enable, tmr_period, wash_done};
  endtask

  task automatic test_reset();
    obs_t o;
    reset = 1'b0;
    #12;
    o = '{phase, tmr_clear, tmr_enable, tmr_period, wash_done};
    n_cmp++;
    if (o !== mk(0, 0, 0, 0, 0)) begin
      n_bad++;
      $display("FAIL reset_state: got %s, want %s", fmt(o), fmt(mk(0, 0, 0, 0, 0)));
    end
    n_cmp++;
    if (tmr_clk_freq !== 16'(F)) begin
      n_bad++;
      $display("FAIL clk_freq: got %0d, want %0d", tmr_clk_freq, F);
    end
    @(posedge clk);
    #1 reset = 1'b1;
    clear_q();
    push_idle(5);
    for (int i = 0; i < exp_q.size(); i++) begin
      step(drv_q[i], o);
      n_cmp++;
      if (o !== exp_q[i]) begin
        n_bad++;
        $display("FAIL idle_no_coin cycle %0d: got %s, want %s", i, fmt(o), fmt(exp_q[i]));
      end
    end
  endtask

  task automatic test_single_run();
    obs_t o;
    clear_q();
    build_run(0, $urandom_range(0, 3), 1, 0, 0, 0, 0, 0, 0);
    push_idle(3);
    for (int i = 0; i < exp_q.size(); i++) begin
      step(drv_q[i], o);
      n_cmp++;
      if (o !== exp_q[i]) begin
        n_bad++;
        $display("FAIL single_run cycle %0d: got %s, want %s", i, fmt(o), fmt(exp_q[i]));
      end
    end
  endtask

  task automatic test_double_wash();
    obs_t o;
    clear_q();
    build_run(1, $urandom_range(0, 3), 1, 0, 0, 0, 0, 0, 0);
    push_idle(3);
    for (int i = 0; i < exp_q.size(); i++) begin
      step(drv_q[i], o);
      n_cmp++;
      if (o !== exp_q[i]) begin
        n_bad++;
        $display("FAIL double_wash cycle %0d: got %s, want %s", i, fmt(o), fmt(exp_q[i]));
      end
    end
  endtask

  task automatic test_door_wait();
    obs_t o;
    clear_q();
    build_run(0, 20, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < exp_q.size(); i++) begin
      step(drv_q[i], o);
      n_cmp++;
      if (o !== exp_q[i]) begin
        n_bad++;
        $display("FAIL door_wait cycle %0d: got %s, want %s", i, fmt(o), fmt(exp_q[i]));
      end
    end
  endtask

  task automatic test_pause();
    obs_t o;
    clear_q();
    build_run(0, 1, $urandom_range(1, F * T_SPIN), 7, $urandom_range(1, 15), 7, 0, 0, 0);
    for (int i = 0; i < exp_q.size(); i++) begin
      step(drv_q[i], o);
      n_cmp++;
      if (o !== exp_q[i]) begin
        n_bad++;
        $display("FAIL pause cycle %0d: got %s, want %s", i, fmt(o), fmt(exp_q[i]));
      end
    end
  endtask

  task automatic test_coin_ignored();
    obs_t o;
    clear_q();
    build_run(0, 0, 1, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < exp_q.size(); i++) begin
      step(drv_q[i], o);
      n_cmp++;
      if (o !== exp_q[i]) begin
        n_bad++;
        $display("FAIL coin_ignored cycle %0d: got %s, want %s", i, fmt(o), fmt(exp_q[i]));
      end
    end
  endtask

  task automatic test_stale_done();
    obs_t o;
    clear_q();
    build_run(0, 0, 1, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < exp_q.size(); i++) begin
      step(drv_q[i], o);
      n_cmp++;
      if (o !== exp_q[i]) begin
        n_bad++;
        $display("FAIL stale_done cycle %0d: got %s, want %s", i, fmt(o), fmt(exp_q[i]));
      end
    end
  endtask

  task automatic test_reset_midrun();
    obs_t o;
    int   stop;
    clear_q();
    build_run(1, 0, 1, 0, 0, 0, 0, 0, 0);
    stop = 0;
    for (int i = 0; i < exp_q.size(); i++)
      if (stop == 0 && exp_q[i].ph == 3'd4) stop = i;
    stop = stop + $urandom_range(1, 5);
    for (int i = 0; i < stop; i++) begin
      step(drv_q[i], o);
      n_cmp++;
      if (o !== exp_q[i]) begin
        n_bad++;
        $display("FAIL reset_midrun_pre cycle %0d: got %s, want %s", i, fmt(o), fmt(exp_q[i]));
      end
    end
    #2;
    reset   = 1'b0;
    coin_in = 1'b0;
    #1;
    o = '{phase, tmr_clear, tmr_enable, tmr_period, wash_done};
    n_cmp++;
    if (o !== mk(0, 0, 0, 0, 0)) begin
      n_bad++;
      $display("FAIL reset_midrun_immediate: got %s, want %s", fmt(o), fmt(mk(0, 0, 0, 0, 0)));
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      o = '{phase, tmr_clear, tmr_enable, tmr_period, wash_done};
      n_cmp++;
      if (o !== mk(0, 0, 0, 0, 0)) begin
        n_bad++;
        $display("FAIL reset_midrun_hold %0d: got %s, want %s", i, fmt(o), fmt(mk(0, 0, 0, 0, 0)));
      end
    end
    @(posedge clk);
    #1 reset = 1'b1;
    clear_q();
    push_idle(4);
    build_run(0, 1, 1, 0, 0, 0, 0, 0, 0);
    push_idle(2);
    for (int i = 0; i < exp_q.size(); i++) begin
      step(drv_q[i], o);
      n_cmp++;
      if (o !== exp_q[i]) begin
        n_bad++;
        $display("FAIL reset_midrun_after cycle %0d: got %s, want %s", i, fmt(o), fmt(exp_q[i]));
      end
    end
  endtask

  task automatic test_back_to_back();
    obs_t o;
    clear_q();
    build_run(rb(), $urandom_range(0, 2), 1, 0, 0, 0, 0, 0, 0);
    build_run(rb(), $urandom_range(0, 2), 1, 0, 0, 0, 0, 0, 1);
    push_idle(3);
    for (int i = 0; i < exp_q.size(); i++) begin
      step(drv_q[i], o);
      n_cmp++;
      if (o !== exp_q[i]) begin
        n_bad++;
        $display("FAIL back_to_back cycle %0d: got %s, want %s", i, fmt(o), fmt(exp_q[i]));
      end
    end
  endtask

  task automatic test_random();
    obs_t o;
    clear_q();
    for (int r = 0; r < 4; r++) begin
      build_run(rb(), $urandom_range(0, 4), $urandom_range(1, F * T_SPIN), $urandom_range(0, 6),
                $urandom_range(0, 20), $urandom_range(0, 8), rb(), rb(), (r > 0) && rb());
    end
    push_idle(2);
    for (int i = 0; i < exp_q.size(); i++) begin
      step(drv_q[i], o);
      n_cmp++;
      if (o !== exp_q[i]) begin
        n_bad++;
        $display("FAIL random cycle %0d: got %s, want %s", i, fmt(o), fmt(exp_q[i]));
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_run();
    test_double_wash();
    test_door_wait();
    test_pause();
    test_coin_ignored();
    test_stale_done();
    test_reset_midrun();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
